// File: rtl/ex_pkg.sv
// Shared types and constants for the RV32I execute stage: ALU opcodes, forwarding and
// writeback selects, and the packed layouts of the ID/EX and EX/ME pipeline registers.
package ex_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic            is_rs2;
        logic            rd_wren;
        logic            is_load;
        logic            mem_wren;
        logic            op_a_sel;
        logic            op_b_sel;
        logic            br_unsigned;
        logic [1:0]      wb_sel;
        logic [2:0]      mem_op;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } id_ex_t;

    typedef struct packed {
        logic            rd_wren;
        logic            is_load;
        logic            mem_wren;
        logic [1:0]      wb_sel;
        logic [2:0]      mem_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] alu_data;
    } ex_me_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit RV32I ALU; results wrap modulo 2^32, unused opcodes return 0.
module ex_alu
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [3:0]      alu_op_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = op_b_i[4:0];

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:    result_o = op_a_i + op_b_i;
            ALU_SUB:    result_o = op_a_i - op_b_i;
            ALU_SLL:    result_o = op_a_i << shamt;
            ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
            ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
            ALU_XOR:    result_o = op_a_i ^ op_b_i;
            ALU_SRL:    result_o = op_a_i >> shamt;
            ALU_SRA:    result_o = $unsigned($signed(op_a_i) >>> shamt);
            ALU_OR:     result_o = op_a_i | op_b_i;
            ALU_AND:    result_o = op_a_i & op_b_i;
            ALU_PASS_B: result_o = op_b_i;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, operand forwarding (enabled by EX_STAGE_FWD_EN),
// operand select, ALU and EX/ME register.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_enable_i,
    input  logic            ex_flush_i,
    input  logic            me_enable_i,
    input  logic            me_flush_i,
    input  logic            id_is_rs2_i,
    input  logic            id_rd_wren_i,
    input  logic            id_is_load_i,
    input  logic            id_mem_wren_i,
    input  logic            id_op_a_sel_i,
    input  logic            id_op_b_sel_i,
    input  logic            id_br_unsigned_i,
    input  logic [1:0]      id_wb_sel_i,
    input  logic [2:0]      id_mem_op_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_instr_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] imm_ex_i,
    input  logic [1:0]      forward_a_i,
    input  logic [1:0]      forward_b_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] ex_instr_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic            ex_is_rs2_o,
    output logic            ex_rd_wren_o,
    output logic            ex_is_load_o,
    output logic            ex_br_unsigned_o,
    output logic [XLEN-1:0] ex_rs1_fwd_o,
    output logic [XLEN-1:0] ex_rs2_fwd_o,
    output logic [XLEN-1:0] ex_alu_data_o,
    output logic            me_rd_wren_o,
    output logic            me_is_load_o,
    output logic            me_mem_wren_o,
    output logic [1:0]      me_wb_sel_o,
    output logic [2:0]      me_mem_op_o,
    output logic [XLEN-1:0] me_pc_o,
    output logic [XLEN-1:0] me_instr_o,
    output logic [XLEN-1:0] me_rs2_data_o,
    output logic [XLEN-1:0] me_alu_data_o
);

    id_ex_t id_ex_d, id_ex_q;
    ex_me_t ex_me_d, ex_me_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_result;

    always_comb begin
        id_ex_d = '{is_rs2: id_is_rs2_i, rd_wren: id_rd_wren_i, is_load: id_is_load_i,
                    mem_wren: id_mem_wren_i, op_a_sel: id_op_a_sel_i,
                    op_b_sel: id_op_b_sel_i, br_unsigned: id_br_unsigned_i,
                    wb_sel: id_wb_sel_i, mem_op: id_mem_op_i, alu_op: id_alu_op_i,
                    pc: id_pc_i, instr: id_instr_i, rs1_data: id_rs1_data_i,
                    rs2_data: id_rs2_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)          id_ex_q <= '0;
        else if (ex_flush_i)  id_ex_q <= '0;
        else if (ex_enable_i) id_ex_q <= id_ex_d;
    end

`ifdef EX_STAGE_FWD_EN
    always_comb begin
        rs1_fwd = '0;
        case (forward_a_i)
            FWD_NONE: rs1_fwd = id_ex_q.rs1_data;
            FWD_MEM:  rs1_fwd = ex_me_q.alu_data;
            FWD_WB:   rs1_fwd = wb_data_i;
            default:  rs1_fwd = '0;
        endcase
    end

    always_comb begin
        rs2_fwd = '0;
        case (forward_b_i)
            FWD_NONE: rs2_fwd = id_ex_q.rs2_data;
            FWD_MEM:  rs2_fwd = ex_me_q.alu_data;
            FWD_WB:   rs2_fwd = wb_data_i;
            default:  rs2_fwd = '0;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{forward_a_i, forward_b_i, wb_data_i};
    assign rs1_fwd    = id_ex_q.rs1_data;
    assign rs2_fwd    = id_ex_q.rs2_data;
`endif

    assign op_a = id_ex_q.op_a_sel ? id_ex_q.pc : rs1_fwd;
    assign op_b = id_ex_q.op_b_sel ? imm_ex_i : rs2_fwd;

    ex_alu u_ex_alu (
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .alu_op_i (id_ex_q.alu_op),
        .result_o (alu_result)
    );

    always_comb begin
        ex_me_d = '{rd_wren: id_ex_q.rd_wren, is_load: id_ex_q.is_load,
                    mem_wren: id_ex_q.mem_wren, wb_sel: id_ex_q.wb_sel,
                    mem_op: id_ex_q.mem_op, pc: id_ex_q.pc, instr: id_ex_q.instr,
                    rs2_data: rs2_fwd, alu_data: alu_result};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)          ex_me_q <= '0;
        else if (me_flush_i)  ex_me_q <= '0;
        else if (me_enable_i) ex_me_q <= ex_me_d;
    end

    assign ex_instr_o       = id_ex_q.instr;
    assign ex_pc_o          = id_ex_q.pc;
    assign ex_is_rs2_o      = id_ex_q.is_rs2;
    assign ex_rd_wren_o     = id_ex_q.rd_wren;
    assign ex_is_load_o     = id_ex_q.is_load;
    assign ex_br_unsigned_o = id_ex_q.br_unsigned;
    assign ex_rs1_fwd_o     = rs1_fwd;
    assign ex_rs2_fwd_o     = rs2_fwd;
    assign ex_alu_data_o    = alu_result;

    assign me_rd_wren_o  = ex_me_q.rd_wren;
    assign me_is_load_o  = ex_me_q.is_load;
    assign me_mem_wren_o = ex_me_q.mem_wren;
    assign me_wb_sel_o   = ex_me_q.wb_sel;
    assign me_mem_op_o   = ex_me_q.mem_op;
    assign me_pc_o       = ex_me_q.pc;
    assign me_instr_o    = ex_me_q.instr;
    assign me_rs2_data_o = ex_me_q.rs2_data;
    assign me_alu_data_o = ex_me_q.alu_data;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; forwarding expectations follow EX_STAGE_FWD_EN.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni, ex_enable_i, ex_flush_i, me_enable_i, me_flush_i;
    logic        id_is_rs2_i, id_rd_wren_i, id_is_load_i, id_mem_wren_i;
    logic        id_op_a_sel_i, id_op_b_sel_i, id_br_unsigned_i;
    logic [1:0]  id_wb_sel_i, forward_a_i, forward_b_i;
    logic [2:0]  id_mem_op_i;
    logic [3:0]  id_alu_op_i;
    logic [31:0] id_pc_i, id_instr_i, id_rs1_data_i, id_rs2_data_i, imm_ex_i, wb_data_i;
    logic [31:0] ex_instr_o, ex_pc_o, ex_rs1_fwd_o, ex_rs2_fwd_o, ex_alu_data_o;
    logic        ex_is_rs2_o, ex_rd_wren_o, ex_is_load_o, ex_br_unsigned_o;
    logic        me_rd_wren_o, me_is_load_o, me_mem_wren_o;
    logic [1:0]  me_wb_sel_o;
    logic [2:0]  me_mem_op_o;
    logic [31:0] me_pc_o, me_instr_o, me_rs2_data_o, me_alu_data_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    ex_stage u_dut (
        .clk_i, .rst_ni, .ex_enable_i, .ex_flush_i, .me_enable_i, .me_flush_i,
        .id_is_rs2_i, .id_rd_wren_i, .id_is_load_i, .id_mem_wren_i, .id_op_a_sel_i,
        .id_op_b_sel_i, .id_br_unsigned_i, .id_wb_sel_i, .id_mem_op_i, .id_alu_op_i,
        .id_pc_i, .id_instr_i, .id_rs1_data_i, .id_rs2_data_i, .imm_ex_i,
        .forward_a_i, .forward_b_i, .wb_data_i,
        .ex_instr_o, .ex_pc_o, .ex_is_rs2_o, .ex_rd_wren_o, .ex_is_load_o,
        .ex_br_unsigned_o, .ex_rs1_fwd_o, .ex_rs2_fwd_o, .ex_alu_data_o,
        .me_rd_wren_o, .me_is_load_o, .me_mem_wren_o, .me_wb_sel_o, .me_mem_op_o,
        .me_pc_o, .me_instr_o, .me_rs2_data_o, .me_alu_data_o
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [3:0] op,
                          input logic a_sel, input logic b_sel);
        id_pc_i       = pc;
        id_instr_i    = pc ^ 32'h0000_0033;
        id_rs1_data_i = rs1;
        id_rs2_data_i = rs2;
        id_alu_op_i   = op;
        id_op_a_sel_i = a_sel;
        id_op_b_sel_i = b_sel;
    endtask

    function automatic logic [31:0] ex_ctrl();
        return {28'd0, ex_is_rs2_o, ex_rd_wren_o, ex_is_load_o, ex_br_unsigned_o};
    endfunction

    function automatic logic [31:0] me_ctrl();
        return {24'd0, me_rd_wren_o, me_is_load_o, me_mem_wren_o, me_wb_sel_o, me_mem_op_o};
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] exp;
        string       tag;
    } alu_vec_t;

    alu_vec_t alu_vecs[12] = '{
        '{4'd7,  32'hFFFF_FFFF, "sra"},  '{4'd6,  32'h0FFF_FFFF, "srl"},
        '{4'd2,  32'hFFFF_FF00, "sll"},  '{4'd3,  32'h0000_0001, "slt"},
        '{4'd4,  32'h0000_0000, "sltu"}, '{4'd10, 32'h0000_0004, "pass_b"},
        '{4'd1,  32'hFFFF_FFEC, "sub"},  '{4'd0,  32'hFFFF_FFF4, "add"},
        '{4'd5,  32'hFFFF_FFF4, "xor"},  '{4'd8,  32'hFFFF_FFF4, "or"},
        '{4'd9,  32'h0000_0000, "and"},  '{4'd12, 32'h0000_0000, "op12"}
    };

    initial begin
        // Reset with every decode input nonzero
        rst_ni = 1'b0;
        ex_enable_i = 1'b1; ex_flush_i = 1'b0; me_enable_i = 1'b1; me_flush_i = 1'b0;
        id_is_rs2_i = 1'b1; id_rd_wren_i = 1'b1; id_is_load_i = 1'b1; id_mem_wren_i = 1'b1;
        id_br_unsigned_i = 1'b1; id_wb_sel_i = 2'd3; id_mem_op_i = 3'd7;
        set_id(32'h1234, 32'h11, 32'h22, 4'd0, 1'b1, 1'b1);
        imm_ex_i = 32'h5; forward_a_i = 2'd0; forward_b_i = 2'd0; wb_data_i = 32'h77;
        step();
        step();
        check("rst_ex_pc", ex_pc_o, 32'h0);
        check("rst_ex_instr", ex_instr_o, 32'h0);
        check("rst_ex_ctrl", ex_ctrl(), 32'h0);
        check("rst_ex_rs1", ex_rs1_fwd_o, 32'h0);
        check("rst_ex_alu", ex_alu_data_o, 32'h0);
        check("rst_me_ctrl", me_ctrl(), 32'h0);
        check("rst_me_pc", me_pc_o, 32'h0);
        check("rst_me_alu", me_alu_data_o, 32'h0);

        // ADD overflow wraps; controls travel through both stages
        rst_ni = 1'b1;
        id_is_rs2_i = 1'b1; id_rd_wren_i = 1'b1; id_is_load_i = 1'b0; id_mem_wren_i = 1'b1;
        id_br_unsigned_i = 1'b1; id_wb_sel_i = 2'd2; id_mem_op_i = 3'b101;
        set_id(32'h40, 32'h7FFF_FFFF, 32'h1, 4'd0, 1'b0, 1'b0);
        step();
        check("add_ex_alu", ex_alu_data_o, 32'h8000_0000);
        check("add_ex_pc", ex_pc_o, 32'h40);
        check("add_ex_ctrl", ex_ctrl(), 32'hD);
        step();
        check("add_me_alu", me_alu_data_o, 32'h8000_0000);
        check("add_me_ctrl", me_ctrl(), 32'hB5);
        check("add_me_instr", me_instr_o, 32'h40 ^ 32'h33);
        check("add_me_rs2", me_rs2_data_o, 32'h1);

        // ALU sweep, A = 0xFFFFFFF0, B = imm 4
        imm_ex_i = 32'h4;
        foreach (alu_vecs[i]) begin
            set_id(32'h80, 32'hFFFF_FFF0, 32'h0, alu_vecs[i].op, 1'b0, 1'b1);
            step();
            check(alu_vecs[i].tag, ex_alu_data_o, alu_vecs[i].exp);
        end

        // Forwarding: put 0x55 into EX/ME, then forward it and wb_data into the next op
        set_id(32'h90, 32'h55, 32'h0, 4'd0, 1'b0, 1'b0);
        step();
        set_id(32'h94, 32'h11, 32'h22, 4'd0, 1'b0, 1'b0);
        step();
        forward_a_i = 2'd1; forward_b_i = 2'd2; wb_data_i = 32'hAA;
        #1;
`ifdef EX_STAGE_FWD_EN
        check("fwd_rs1_mem", ex_rs1_fwd_o, 32'h55);
        check("fwd_rs2_wb", ex_rs2_fwd_o, 32'hAA);
        check("fwd_alu", ex_alu_data_o, 32'hFF);
`else
        check("nofwd_rs1", ex_rs1_fwd_o, 32'h11);
        check("nofwd_rs2", ex_rs2_fwd_o, 32'h22);
        check("nofwd_alu", ex_alu_data_o, 32'h33);
`endif
        ex_enable_i = 1'b0;
        step();
`ifdef EX_STAGE_FWD_EN
        check("fwd_me_rs2", me_rs2_data_o, 32'hAA);
        forward_a_i = 2'd3;
        #1;
        check("fwd_zero", ex_rs1_fwd_o, 32'h0);
`else
        check("nofwd_me_rs2", me_rs2_data_o, 32'h22);
`endif
        forward_a_i = 2'd0; forward_b_i = 2'd0;
        ex_enable_i = 1'b1;

        // Stall: ID/EX holds, EX/ME keeps loading the held instruction
        set_id(32'h200, 32'h5, 32'h6, 4'd0, 1'b0, 1'b0);
        step();
        check("stall_load_pc", ex_pc_o, 32'h200);
        ex_enable_i = 1'b0;
        set_id(32'h300, 32'h9, 32'h9, 4'd1, 1'b0, 1'b0);
        step();
        step();
        check("stall_ex_pc", ex_pc_o, 32'h200);
        check("stall_ex_alu", ex_alu_data_o, 32'hB);
        check("stall_me_pc", me_pc_o, 32'h200);
        check("stall_me_alu", me_alu_data_o, 32'hB);

        // EX/ME hold while ID/EX advances
        ex_enable_i = 1'b1; me_enable_i = 1'b0;
        step();
        check("mehold_ex_pc", ex_pc_o, 32'h300);
        check("mehold_me_pc", me_pc_o, 32'h200);

        // Flush beats enable in each stage
        ex_flush_i = 1'b1;
        step();
        check("flush_ex_pc", ex_pc_o, 32'h0);
        check("flush_ex_ctrl", ex_ctrl(), 32'h0);
        check("flush_ex_alu", ex_alu_data_o, 32'h0);
        ex_flush_i = 1'b0; me_enable_i = 1'b1; me_flush_i = 1'b1;
        step();
        check("flush_me_pc", me_pc_o, 32'h0);
        check("flush_me_ctrl", me_ctrl(), 32'h0);
        me_flush_i = 1'b0;

        // PC + immediate
        imm_ex_i = 32'h20;
        set_id(32'h100, 32'hDEAD, 32'hBEEF, 4'd0, 1'b1, 1'b1);
        step();
        check("pc_ex_alu", ex_alu_data_o, 32'h120);
        step();
        check("pc_me_pc", me_pc_o, 32'h100);
        check("pc_me_alu", me_alu_data_o, 32'h120);

        // Reset mid-operation clears both stages on the next edge
        rst_ni = 1'b0;
        step();
        check("midrst_ex_pc", ex_pc_o, 32'h0);
        check("midrst_me_pc", me_pc_o, 32'h0);
        check("midrst_me_alu", me_alu_data_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute-stage slice of the 5-stage RV32I pipeline. It contains the ID/EX pipeline register, the operand forwarding muxes, the operand A/B select muxes, a combinational ALU and the EX/ME pipeline register.
- It sits between decode (register file and control unit) and the load/store unit.
- It exports EX-stage values for branch compare, the immediate generator and next-PC selection.

Parameters:
- XLEN, 32, datapath width. Only 32 is required.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  synchronous active-low reset
- ex_enable_i  in  1  ID/EX load enable; 0 = hold
- ex_flush_i  in  1  synchronous bubble insert into ID/EX
- me_enable_i  in  1  EX/ME load enable; 0 = hold
- me_flush_i  in  1  synchronous bubble insert into EX/ME
- id_is_rs2_i, id_rd_wren_i, id_is_load_i, id_mem_wren_i, id_op_a_sel_i, id_op_b_sel_i, id_br_unsigned_i  in  1 each  decode control
- id_wb_sel_i  in  2  writeback select
- id_mem_op_i  in  3  memory access type
- id_alu_op_i  in  4  ALU operation
- id_pc_i, id_instr_i, id_rs1_data_i, id_rs2_data_i  in  32 each  decode data
- imm_ex_i  in  32  immediate from the external immgen, decoded from instr_ex_o
- forward_a_i, forward_b_i  in  2  forwarding selects
- wb_data_i  in  32  writeback-stage result, used for forwarding
- ex_instr_o, ex_pc_o  out  32  registered EX-stage instruction and PC
- ex_is_rs2_o, ex_rd_wren_o, ex_is_load_o, ex_br_unsigned_o  out  1  registered EX-stage control
- ex_rs1_fwd_o, ex_rs2_fwd_o  out  32  forwarded register operands, to the branch comparator
- ex_alu_data_o  out  32  ALU result, also used as the branch/jump target
- me_rd_wren_o, me_is_load_o, me_mem_wren_o  out  1  ME-stage control
- me_wb_sel_o  out  2  ME-stage writeback select
- me_mem_op_o  out  3  ME-stage memory access type
- me_pc_o, me_instr_o, me_rs2_data_o, me_alu_data_o  out  32  ME-stage data

Behaviour:
- Register update priority, evaluated per register on every rising edge:
  - rst_ni=0 loads all fields with 0.
  - Otherwise, the stage flush loads all fields with 0.
  - Otherwise, enable=1 loads the new values.
  - Otherwise the register holds.
- All outputs are 0 after reset. An all-zero bubble has rd_wren=0 and mem_wren=0, so it is architecturally inert.
- ID/EX captures every id_* input.
- Forward mux A, selected by forward_a_i, produces rs1_fwd:
  - 0 selects the registered rs1_data.
  - 1 selects me_alu_data_o.
  - 2 selects wb_data_i.
  - 3 selects 0.
- Forward mux B is identical, selected by forward_b_i, and produces rs2_fwd.
- Operand A = ex_pc_o when op_a_sel=1, else rs1_fwd. Operand B = imm_ex_i when op_b_sel=1, else rs2_fwd.
- ALU is purely combinational, 32-bit, and wraps modulo 2^32. Operation by alu_op:
  - 0 ADD, 1 SUB.
  - 2 SLL, 6 SRL, 7 SRA; shift amount = B[4:0].
  - 3 SLT (signed compare), 4 SLTU (unsigned compare); both return 0 or 1.
  - 5 XOR, 8 OR, 9 AND.
  - 10 PASS_B (LUI).
  - Codes 11-15 return 0.
- EX/ME captures:
  - control signals rd_wren, is_load, mem_wren, wb_sel, mem_op;
  - pc and instr;
  - rs2_fwd as rs2_data;
  - the ALU result as alu_data.
- Latency: one cycle from the id_* inputs to the ex_* outputs, one further cycle to the me_* outputs. The ALU path from the ID/EX register to ex_alu_data_o is combinational.
- Simultaneous flush and enable: flush wins.
- ex_enable_i=0 with me_enable_i=1: EX/ME still loads the held instruction.
- Reset asserted mid-operation clears both stages on the next edge.
- Forwarding from me_alu_data_o uses the pre-edge value. The forwarded data is combinational within the cycle.

Optional Feature:
- Macro EX_STAGE_FWD_EN.
- When defined: the forwarding muxes are implemented as described in Behaviour.
- When undefined: forward_a_i, forward_b_i and wb_data_i are ignored, and rs1_fwd/rs2_fwd equal the registered rs1_data/rs2_data.

Decomposition:
- Shared package ex_pkg holds:
  - ALU opcode constants (ALU_ADD ... ALU_PASS_B, 4-bit);
  - forwarding select constants FWD_NONE=0, FWD_MEM=1, FWD_WB=2;
  - writeback select constants WB_ALU, WB_LOAD, WB_PC4;
  - packed structs for the ID/EX and EX/ME register contents.
- One sub-module, ex_alu, contains the combinational ALU. Both pipeline registers stay inline in ex_stage.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with nonzero id_* inputs -> all ex_* and me_* outputs are 0.
- ADD: rs1=0x7FFFFFFF, rs2=1, op_b_sel=0, alu_op=ADD, enables=1.
  - Next cycle: ex_alu_data_o=0x80000000.
  - Cycle after: me_alu_data_o=0x80000000.
- ALU sweep with A=0xFFFFFFF0, B=4 (imm, op_b_sel=1) -> required results:
  - SRA 0xFFFFFFFF, SRL 0x0FFFFFFF, SLL 0xFFFFFF00;
  - SLT 1, SLTU 0;
  - PASS_B 4, SUB 0xFFFFFFEC.
- Forwarding:
  - me_alu_data_o=0x55, wb_data_i=0xAA, forward_a_i=1, forward_b_i=2 -> ex_rs1_fwd_o=0x55, ex_rs2_fwd_o=0xAA.
  - The next EX/ME capture has me_rs2_data_o=0xAA.
  - With EX_STAGE_FWD_EN undefined, both follow the registered data.
- Stall/flush: ex_enable_i=0 for 2 cycles -> ex_* values held. ex_flush_i=1 together with ex_enable_i=1 -> ex_* outputs are 0 next cycle.
- PC operand: pc=0x100, imm=0x20, op_a_sel=1, op_b_sel=1, ADD -> ex_alu_data_o=0x120, and me_pc_o=0x100 one cycle later.
